// File: rtl/uart_tx_puntaje_pkg.sv
// Shared constants, state encoding and ASCII helpers for the score transmitter.
package uart_tx_puntaje_pkg;

    localparam logic [7:0] ASCII_0   = 8'h30;
    localparam logic [7:0] ASCII_ERR = 8'h3F;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;

    localparam int MSG_LEN = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        if (d <= 4'd9) begin
            return ASCII_0 + {4'h0, d};
        end
        return ASCII_ERR;
    endfunction

    // Message layout: hundreds, tens, units, CR, LF.
    function automatic logic [7:0] msg_byte(input logic [2:0] idx,
                                            input logic [3:0] cen,
                                            input logic [3:0] dec,
                                            input logic [3:0] uni);
        case (idx)
            3'd0:    return digit_ascii(cen);
            3'd1:    return digit_ascii(dec);
            3'd2:    return digit_ascii(uni);
            3'd3:    return ASCII_CR;
            default: return ASCII_LF;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_puntaje_byte.sv
// 8N1 byte serializer; a byte offered on the last stop-bit cycle follows with no idle gap.
//   state    | meaning
//   ST_IDLE  | line high, waiting for valido
//   ST_START | driving start bit (0)
//   ST_DATA  | shifting 8 data bits, LSB first
//   ST_STOP  | driving stop bit (1); may chain straight into the next start bit
module uart_tx_byte
    import uart_tx_puntaje_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] dato,
    input  logic       valido,
    output logic       tx,
    output logic       listo,
    output logic       fin_byte
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t         state, state_d;
    logic [BAUD_W-1:0] baud_cnt, baud_cnt_d;
    logic [2:0]        bit_idx, bit_idx_d;
    logic [7:0]        shreg, shreg_d;
    logic              tx_q, tx_d;
    logic              baud_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_cnt_d;
            bit_idx  <= bit_idx_d;
            shreg    <= shreg_d;
            tx_q     <= tx_d;
        end
    end

    assign baud_end = (baud_cnt == BAUD_LAST);

    always_comb begin
        state_d    = state;
        baud_cnt_d = baud_cnt;
        bit_idx_d  = bit_idx;
        shreg_d    = shreg;
        case (state)
            ST_IDLE: begin
                baud_cnt_d = '0;
                bit_idx_d  = '0;
                if (valido) begin
                    state_d = ST_START;
                    shreg_d = dato;
                end
            end
            ST_START: begin
                baud_cnt_d = baud_end ? '0 : baud_cnt + 1'b1;
                if (baud_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                baud_cnt_d = baud_end ? '0 : baud_cnt + 1'b1;
                if (baud_end) begin
                    shreg_d   = {1'b0, shreg[7:1]};
                    bit_idx_d = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                baud_cnt_d = baud_end ? '0 : baud_cnt + 1'b1;
                if (baud_end) begin
                    if (valido) begin
                        state_d = ST_START;
                        shreg_d = dato;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // tx is registered from the next-state view so the line changes on the accepting edge.
    always_comb begin
        tx_d     = 1'b1;
        listo    = (state == ST_IDLE);
        fin_byte = (state == ST_STOP) && baud_end;
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shreg_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx = tx_q;

endmodule

// File: rtl/uart_tx_puntaje.sv
// Score transmitter: latches three BCD digits on a send request and emits them
// as ASCII followed by CR LF over an 8N1 serial line.
module uart_tx_puntaje #(
    parameter int CLKS_PER_BIT = 868,
    parameter int MSG_LEN      = uart_tx_puntaje_pkg::MSG_LEN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enviar,
    input  logic [3:0] centenas,
    input  logic [3:0] decenas,
    input  logic [3:0] unidades,
    output logic       tx,
    output logic       ocupado,
    output logic       terminado
);

    import uart_tx_puntaje_pkg::*;

    localparam logic [2:0] LAST_IDX = 3'(MSG_LEN - 1);

    logic [3:0] cen_q, dec_q, uni_q;
    logic [2:0] byte_idx;
    logic       ocupado_q, terminado_q;
    logic       aceptar, ultimo, valido;
    logic       listo, fin_byte;
    logic [7:0] dato;

    assign aceptar = enviar && !ocupado_q && listo;
    assign ultimo  = (byte_idx == LAST_IDX);
    assign valido  = aceptar || (fin_byte && !ultimo);

    // First byte comes straight from the inputs; later bytes from the latched digits.
    assign dato = ocupado_q ? msg_byte(byte_idx + 3'd1, cen_q, dec_q, uni_q)
                            : digit_ascii(centenas);

    always_ff @(posedge clk) begin
        if (reset) begin
            ocupado_q   <= 1'b0;
            terminado_q <= 1'b0;
            byte_idx    <= '0;
            cen_q       <= '0;
            dec_q       <= '0;
            uni_q       <= '0;
        end else begin
            terminado_q <= 1'b0;
            if (aceptar) begin
                ocupado_q <= 1'b1;
                byte_idx  <= '0;
                cen_q     <= centenas;
                dec_q     <= decenas;
                uni_q     <= unidades;
            end else if (fin_byte) begin
                if (ultimo) begin
                    ocupado_q   <= 1'b0;
                    terminado_q <= 1'b1;
                end else begin
                    byte_idx <= byte_idx + 3'd1;
                end
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk      (clk),
        .reset    (reset),
        .dato     (dato),
        .valido   (valido),
        .tx       (tx),
        .listo    (listo),
        .fin_byte (fin_byte)
    );

    assign ocupado   = ocupado_q;
    assign terminado = terminado_q;

endmodule

// File: tb/tb_uart_tx_puntaje.sv
// Bench for uart_tx_puntaje: per-cycle line model plus a serial decoder checked against hand-written bytes.
module tb_uart_tx_puntaje;

    localparam int CPB     = 4;
    localparam int MSG_CYC = 5 * 10 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enviar = 1'b0;
    logic [3:0] centenas = 4'h0;
    logic [3:0] decenas = 4'h0;
    logic [3:0] unidades = 4'h0;
    logic       tx, ocupado, terminado;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    bit rst_q = 1'b0;
    bit m_term = 1'b0;
    bit m_busy;
    bit q_exp[$];
    int acc_cyc[$];
    int term_cyc[$];
    int rx_start[$];
    logic [7:0] rx_bytes[$];
    bit rx_act = 1'b0;
    int rx_cnt = 0;
    logic [7:0] rx_sh = 8'h00;
    int ocup_cnt = 0;
    int t0, t1;

    uart_tx_puntaje #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enviar    (enviar),
        .centenas  (centenas),
        .decenas   (decenas),
        .unidades  (unidades),
        .tx        (tx),
        .ocupado   (ocupado),
        .terminado (terminado)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [3:0] d);
        return (d < 4'd10) ? (8'h30 + {4'h0, d}) : 8'h3F;
    endfunction

    // Expected line level for every cycle of one message.
    function automatic void push_msg(input logic [3:0] c, input logic [3:0] d, input logic [3:0] u);
        logic [7:0] m [5];
        m[0] = exp_byte(c);
        m[1] = exp_byte(d);
        m[2] = exp_byte(u);
        m[3] = 8'h0D;
        m[4] = 8'h0A;
        for (int b = 0; b < 5; b++) begin
            for (int k = 0; k < 10; k++) begin
                bit v;
                v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : m[b][k-1];
                for (int r = 0; r < CPB; r++) q_exp.push_back(v);
            end
        end
    endfunction

    always @(posedge clk) begin
        cyc++;
        rst_q  = reset;
        m_busy = (q_exp.size() > 0);
        m_term = 1'b0;
        if (reset) begin
            q_exp.delete();
        end else begin
            if (m_busy) begin
                void'(q_exp.pop_front());
                if (q_exp.size() == 0) m_term = 1'b1;
            end
            if (enviar && !m_busy) begin
                push_msg(centenas, decenas, unidades);
                acc_cyc.push_back(cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("tx_line", {31'd0, tx}, (q_exp.size() > 0) ? {31'd0, q_exp[0]} : 32'd1);
            chk("ocupado", {31'd0, ocupado}, {31'd0, q_exp.size() > 0});
            chk("terminado", {31'd0, terminado}, {31'd0, m_term});
            if (terminado === 1'b1) term_cyc.push_back(cyc);
            if (ocupado === 1'b1) ocup_cnt++;
            if (rst_q) begin
                rx_act = 1'b0;
            end else if (!rx_act) begin
                if (tx === 1'b0) begin
                    rx_act = 1'b1;
                    rx_cnt = 0;
                    rx_start.push_back(cyc);
                end
            end else begin
                rx_cnt++;
                if (rx_cnt % CPB == CPB / 2) begin
                    if (rx_cnt / CPB == 0) begin
                        chk("start_bit", {31'd0, tx}, 32'd0);
                    end else if (rx_cnt / CPB <= 8) begin
                        rx_sh[rx_cnt / CPB - 1] = tx;
                    end else begin
                        chk("stop_bit", {31'd0, tx}, 32'd1);
                        rx_bytes.push_back(rx_sh);
                        rx_act = 1'b0;
                    end
                end
            end
        end
    end

    task automatic clear_logs();
        rx_bytes.delete();
        term_cyc.delete();
        acc_cyc.delete();
        rx_start.delete();
        ocup_cnt = 0;
    endtask

    task automatic send(input logic [3:0] c, input logic [3:0] d, input logic [3:0] u, output int t);
        centenas = c;
        decenas  = d;
        unidades = u;
        enviar   = 1'b1;
        @(negedge clk);
        enviar   = 1'b0;
        centenas = 4'h8;
        decenas  = 4'h8;
        unidades = 4'h8;
        t = cyc;
        chk("tx_low_on_accept", {31'd0, tx}, 32'd0);
        chk("ocupado_on_accept", {31'd0, ocupado}, 32'd1);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_done(input int n, input int budget);
        int k;
        k = 0;
        while (term_cyc.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (term_cyc.size() < n) chk("terminado_timeout", 32'(term_cyc.size()), 32'(n));
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_msg(input string name, input int off, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
        logic [7:0] e [5];
        e[0] = b0; e[1] = b1; e[2] = b2; e[3] = b3; e[4] = b4;
        for (int i = 0; i < 5; i++) begin
            if (off + i < rx_bytes.size())
                chk($sformatf("%s_byte%0d", name, i), {24'd0, rx_bytes[off + i]}, {24'd0, e[i]});
            else
                chk($sformatf("%s_missing_byte%0d", name, i), 32'(rx_bytes.size()), 32'(off + i + 1));
        end
    endtask

    initial begin
        // 1: reset then idle
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_ocupado", {31'd0, ocupado}, 32'd0);
        chk("rst_terminado", {31'd0, terminado}, 32'd0);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        chk("idle_tx", {31'd0, tx}, 32'd1);
        chk("idle_no_terminado", 32'(term_cyc.size()), 32'd0);

        // 2: basic message 1,2,3
        clear_logs();
        send(4'd1, 4'd2, 4'd3, t0);
        wait_done(1, 3 * MSG_CYC);
        chk_msg("t2", 0, 8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A);
        chk("t2_byte_count", 32'(rx_bytes.size()), 32'd5);
        chk("t2_term_count", 32'(term_cyc.size()), 32'd1);
        if (term_cyc.size() > 0) chk("t2_term_time", 32'(term_cyc[0] - t0), 32'd200);
        chk("t2_ocupado_cycles", 32'(ocup_cnt), 32'd200);

        // 3: request while busy is dropped
        clear_logs();
        send(4'd1, 4'd2, 4'd3, t0);
        wait_cyc(t0 + 39);
        centenas = 4'd9;
        decenas  = 4'd9;
        unidades = 4'd9;
        enviar   = 1'b1;
        @(negedge clk);
        enviar   = 1'b0;
        wait_done(1, 3 * MSG_CYC);
        repeat (MSG_CYC / 2) @(negedge clk);
        chk_msg("t3", 0, 8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A);
        chk("t3_byte_count", 32'(rx_bytes.size()), 32'd5);
        chk("t3_term_count", 32'(term_cyc.size()), 32'd1);

        // 4: out-of-range digits
        clear_logs();
        send(4'hA, 4'h0, 4'hF, t0);
        wait_done(1, 3 * MSG_CYC);
        chk_msg("t4", 0, 8'h3F, 8'h30, 8'h3F, 8'h0D, 8'h0A);

        // 5: reset in the middle of byte 1
        clear_logs();
        send(4'd1, 4'd2, 4'd3, t0);
        wait_cyc(t0 + 57);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t5_tx_after_reset", {31'd0, tx}, 32'd1);
        chk("t5_ocupado_after_reset", {31'd0, ocupado}, 32'd0);
        repeat (MSG_CYC) @(negedge clk);
        chk("t5_no_terminado", 32'(term_cyc.size()), 32'd0);
        chk("t5_partial_count", 32'(rx_bytes.size()), 32'd1);
        if (rx_bytes.size() > 0) chk("t5_first_byte", {24'd0, rx_bytes[0]}, 32'h31);
        clear_logs();
        send(4'd0, 4'd0, 4'd7, t0);
        wait_done(1, 3 * MSG_CYC);
        chk_msg("t5b", 0, 8'h30, 8'h30, 8'h37, 8'h0D, 8'h0A);

        // 6: enviar held high chains two messages
        clear_logs();
        centenas = 4'd0;
        decenas  = 4'd5;
        unidades = 4'd0;
        enviar   = 1'b1;
        t1 = 0;
        while (acc_cyc.size() < 2 && t1 < 3 * MSG_CYC) begin
            @(negedge clk);
            t1++;
        end
        enviar = 1'b0;
        wait_done(2, 3 * MSG_CYC);
        chk("t6_byte_count", 32'(rx_bytes.size()), 32'd10);
        chk_msg("t6a", 0, 8'h30, 8'h35, 8'h30, 8'h0D, 8'h0A);
        chk_msg("t6b", 5, 8'h30, 8'h35, 8'h30, 8'h0D, 8'h0A);
        chk("t6_term_count", 32'(term_cyc.size()), 32'd2);
        if (rx_start.size() >= 6 && term_cyc.size() >= 1) begin
            chk("t6_restart_after_terminado", 32'(rx_start[5] - term_cyc[0]), 32'd1);
            chk("t6_message_spacing", 32'(rx_start[5] - rx_start[0]), 32'd201);
        end else begin
            chk("t6_start_count", 32'(rx_start.size()), 32'd10);
        end

        repeat (10) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_puntaje.md
Name: uart_tx_puntaje

Overview:
UART transmitter, the outbound counterpart of the hand-position UART receiver. On a send request it serializes the current game score, held as three BCD digits, back to the host PC. The message is 5 bytes: hundreds, tens and units as ASCII digits, then CR, then LF. It sits beside registro_puntaje / Bin_to_BCD and shares clk/reset with the rest of the design. It drives one serial line plus busy/done status.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200 baud); legal range >= 2.
MSG_LEN, 5, bytes per message (fixed by the message format; not intended to be overridden).

Ports:
clk  input  1  system clock.
reset  input  1  synchronous reset, active-high.
enviar  input  1  send request; sampled every cycle, acted on only when ocupado=0.
centenas  input  4  BCD hundreds digit.
decenas  input  4  BCD tens digit.
unidades  input  4  BCD units digit.
tx  output  1  serial line; idle high; 8N1 format, LSB first.
ocupado  output  1  high while a message is in flight.
terminado  output  1  one-cycle pulse when the last stop bit of a message completes.

Behaviour:
- Reset (synchronous, active-high) gives tx=1, ocupado=0, terminado=0. Byte index, bit index and baud counter clear; FSM goes to IDLE.
- Reset mid-message aborts the message. From the next edge tx=1 and ocupado=0; no partial frame is resumed.
- Accept rule: enviar=1 with ocupado=0 latches all three digits into internal registers on that edge. Digit inputs may change afterwards with no effect on the message.
- enviar while ocupado=1 is ignored. It is not queued.
- ocupado rises, and tx falls (start bit), on the edge that samples the accepted enviar. tx is a registered output with 1-cycle latency from enviar.
- Byte encoding: a digit value 0-9 maps to 0x30+value. A digit value 10-15 maps to 0x3F ('?'). Byte 3 is 0x0D; byte 4 is 0x0A.
- Frame per byte: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles.
- Bytes are sent back-to-back: the next start bit follows the previous stop bit immediately, with no extra idle cycles.
- FSM states and transitions:
  - IDLE: go to START on an accepted enviar.
  - START: go to DATA after CLKS_PER_BIT cycles.
  - DATA: go to STOP after 8 bits.
  - STOP: after CLKS_PER_BIT cycles, go to START if byte index < MSG_LEN-1 (index increments); otherwise go to IDLE.
- Message duration is MSG_LEN*10*CLKS_PER_BIT cycles, measured from tx falling to the end of the last stop bit.
- On the STOP→IDLE edge: terminado=1 for exactly one cycle, ocupado=0, tx=1.
- Simultaneous events:
  - enviar during the terminado cycle is accepted, since ocupado=0. The next start bit then begins one cycle after the terminado cycle.
  - reset has priority over enviar.
- Baud counter is width clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 on a bit boundary.
- Byte index is 3 bits and bit index is 3 bits. Neither index ever exceeds its terminal value.

Decomposition:
- Shared package:
  - ASCII_0=8'h30, ASCII_ERR=8'h3F, ASCII_CR=8'h0D, ASCII_LF=8'h0A.
  - MSG_LEN=5.
  - FSM state encoding for IDLE/START/DATA/STOP.
- Sub-module uart_tx_byte: byte serializer with CLKS_PER_BIT.
  - Inputs: clk, reset, dato[7:0], valido.
  - Outputs: tx, listo, fin_byte (pulse).
  - uart_tx_puntaje keeps only the digit latch, the ASCII mux and the byte-index sequencer.

Test Plan (CLKS_PER_BIT=4; message = 200 cycles):
1. Assert reset for 2 cycles → tx=1, ocupado=0, terminado=0; hold enviar=0 for 50 cycles → outputs stay unchanged.
2. centenas=1, decenas=2, unidades=3, enviar=1 for 1 cycle (edge T) → tx=0 from T; decoded bytes 0x31,0x32,0x33,0x0D,0x0A; each bit 4 cycles; terminado pulses exactly once at T+200; ocupado=1 for cycles T..T+199.
3. At T+40, change digits to 9,9,9 and pulse enviar → ignored; bytes still 0x31,0x32,0x33,0x0D,0x0A; exactly one terminado.
4. centenas=4'hA, decenas=0, unidades=4'hF → bytes 0x3F,0x30,0x3F,0x0D,0x0A.
5. reset asserted at T+57 (mid data bit of byte 1) → tx=1 and ocupado=0 from T+58; no terminado; new enviar with digits 0,0,7 → full message 0x30,0x30,0x37,0x0D,0x0A.
6. Hold enviar=1 continuously with digits 0,5,0 → second message's start bit begins the cycle after terminado; two consecutive messages with no gap and no corrupted byte.
